// File: rtl/tpu_result_drain.sv
// Result drain for the TPU array: snapshots acc_in LAT cycles after start, then streams
// the N lanes over valid/ready. Define TPU_DRAIN_SATURATE_EN to clip lanes instead of truncating.
module tpu_result_drain #(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int LAT       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*ACC_WIDTH-1:0] acc_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_last,
    output logic                   out_sat,
    output logic                   busy,
    output logic                   overrun
);
    localparam int PW = $clog2(N);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [N*ACC_WIDTH-1:0] snap_q, snap_d;
    logic                   overrun_q, overrun_d;
    logic                   last_s;
    logic                   hs_s;
`ifdef TPU_DRAIN_SATURATE_EN
    logic [ACC_WIDTH-1:0]   lane_s;
`endif

    assign last_s  = (ptr_q == PW'(N - 1));
    assign busy    = (state_q != S_IDLE);
    assign overrun = overrun_q;

    // Output word view of the current snapshot lane; everything reads zero outside DRAIN
    always_comb begin
        out_valid = (state_q == S_DRAIN);
        out_data  = '0;
        out_col   = '0;
        out_last  = 1'b0;
        out_sat   = 1'b0;
`ifdef TPU_DRAIN_SATURATE_EN
        lane_s    = snap_q[ptr_q*ACC_WIDTH +: ACC_WIDTH];
`endif
        if (out_valid) begin
            out_col  = ptr_q;
            out_last = last_s;
`ifdef TPU_DRAIN_SATURATE_EN
            // Any bit above OUT_WIDTH means the lane does not fit and is clipped
            if ((lane_s >> OUT_WIDTH) != '0) begin
                out_data = '1;
                out_sat  = 1'b1;
            end else begin
                out_data = lane_s[OUT_WIDTH-1:0];
                out_sat  = 1'b0;
            end
`else
            out_data = snap_q[ptr_q*ACC_WIDTH +: OUT_WIDTH];
`endif
        end else begin
            out_data = '0;
        end
    end

    // Next-state logic for the collection FSM, counter, lane pointer and snapshot
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        hs_s      = out_valid && out_ready;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(LAT - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (start) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (cnt_q == '0) begin
                    snap_d  = acc_in;
                    ptr_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRAIN: begin
                // A start coinciding with the final handshake chains the next collection
                if (hs_s && last_s) begin
                    ptr_d = '0;
                    if (start) begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LAT - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (hs_s) begin
                        ptr_d = ptr_q + PW'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                    if (start) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain: expected beats are queued at start and popped on handshakes.
module tb_tpu_result_drain;
    localparam int N         = 4;
    localparam int ACC_WIDTH = 24;
    localparam int OUT_WIDTH = 16;
    localparam int LAT       = 5;
    localparam int CW        = $clog2(N);
    localparam logic [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 << OUT_WIDTH) - 1);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [CW-1:0]        col;
        logic                 last;
        logic                 sat;
    } beat_t;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [N*ACC_WIDTH-1:0] acc_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   out_data;
    logic [CW-1:0]          out_col;
    logic                   out_last;
    logic                   out_sat;
    logic                   busy;
    logic                   overrun;

    int    tests_run = 0;
    int    fails     = 0;
    beat_t sb[$];
    beat_t exp_b;

    localparam logic [N*ACC_WIDTH-1:0] BUS_A = {24'd400, 24'd300, 24'd200, 24'd100};
    localparam logic [N*ACC_WIDTH-1:0] BUS_B = {24'd44, 24'd33, 24'd22, 24'd11};
    localparam logic [N*ACC_WIDTH-1:0] BUS_S = {24'd65536, 24'd65535, 24'd5, 24'd70000};
    localparam logic [N*ACC_WIDTH-1:0] BUS_7 = {24'd7, 24'd7, 24'd7, 24'd7};

    tpu_result_drain #(.N(N), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .out_sat(out_sat),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t model_beat(input logic [ACC_WIDTH-1:0] v, input int c);
        beat_t b;
        b.col  = CW'(c);
        b.last = (c == N - 1);
`ifdef TPU_DRAIN_SATURATE_EN
        if (v > MAXV) begin
            b.data = '1;
            b.sat  = 1'b1;
        end else begin
            b.data = v[OUT_WIDTH-1:0];
            b.sat  = 1'b0;
        end
`else
        b.data = v[OUT_WIDTH-1:0];
        b.sat  = 1'b0;
`endif
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge and queues the beats the snapshot of bus should produce
    task automatic start_collection(input logic [N*ACC_WIDTH-1:0] bus);
        acc_in = bus;
        start  = 1'b1;
        for (int i = 0; i < N; i++) sb.push_back(model_beat(bus[i*ACC_WIDTH +: ACC_WIDTH], i));
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({out_valid, out_data, out_col, out_last, out_sat, busy, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0b d=%0d c=%0d l=%0b s=%0b b=%0b o=%0b, want all 0",
                     out_valid, out_data, out_col, out_last, out_sat, busy, overrun);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: got valid=%0b busy=%0b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic_drain();
        int cyc;
        out_ready = 1'b1;
        start_collection(BUS_A);
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_start: got busy=%0b valid=%0b, want 1 0", busy, out_valid);
        end
        for (int i = 1; i < LAT; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL basic_early_valid: cycle %0d got valid=%0b, want 0", i, out_valid);
            end
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency: got valid=%0b, want 1", out_valid);
        end
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                exp_b = sb[0];
                tests_run++;
                if ({out_data, out_col, out_last, out_sat} !== exp_b) begin
                    fails++;
                    $display("FAIL basic_beat: got d=%0d c=%0d l=%0b s=%0b, want d=%0d c=%0d l=%0b s=%0b",
                             out_data, out_col, out_last, out_sat, exp_b.data, exp_b.col, exp_b.last, exp_b.sat);
                end
                void'(sb.pop_front());
            end
            tick();
            cyc++;
        end
        tests_run++;
        if (sb.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_end: got left=%0d busy=%0b valid=%0b, want 0 0 0", sb.size(), busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int stall;
        out_ready = 1'b1;
        start_collection(BUS_A);
        for (int i = 0; i < LAT; i++) tick();
        cyc   = 0;
        stall = 0;
        while (sb.size() > 0 && cyc < 40) begin
            out_ready = !(out_valid && out_col == CW'(1) && stall < 3);
            if (out_valid) begin
                exp_b = sb[0];
                tests_run++;
                if ({out_data, out_col, out_last, out_sat} !== exp_b) begin
                    fails++;
                    $display("FAIL bp_beat: got d=%0d c=%0d l=%0b s=%0b, want d=%0d c=%0d l=%0b s=%0b",
                             out_data, out_col, out_last, out_sat, exp_b.data, exp_b.col, exp_b.last, exp_b.sat);
                end
                if (out_ready) void'(sb.pop_front());
                else stall++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        tests_run++;
        if (sb.size() != 0 || stall != 3 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_end: got left=%0d stalls=%0d valid=%0b, want 0 3 0", sb.size(), stall, out_valid);
        end
    endtask

    task automatic test_snapshot_isolation();
        int cyc;
        out_ready = 1'b1;
        start_collection(BUS_A);
        for (int i = 0; i < LAT; i++) tick();
        acc_in = BUS_7;
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                exp_b = sb[0];
                tests_run++;
                if ({out_data, out_col, out_last, out_sat} !== exp_b) begin
                    fails++;
                    $display("FAIL snap_beat: got d=%0d c=%0d, want d=%0d c=%0d",
                             out_data, out_col, exp_b.data, exp_b.col);
                end
                void'(sb.pop_front());
            end
            tick();
            cyc++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL snap_end: got %0d beats missing, want 0", sb.size());
        end
    endtask

    task automatic test_overrun_back_to_back();
        int cyc;
        out_ready = 1'b1;
        start_collection(BUS_A);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (overrun !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL ovr_set: got ovr=%0b busy=%0b valid=%0b, want 1 1 0", overrun, busy, out_valid);
        end
        for (int i = 3; i < LAT; i++) tick();
        tests_run++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ovr_no_restart: got valid=%0b at original capture, want 1", out_valid);
        end
        for (int i = 0; i < N; i++) begin
            exp_b = sb.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || {out_data, out_col, out_last, out_sat} !== exp_b) begin
                fails++;
                $display("FAIL b2b_first_beat: got v=%0b d=%0d c=%0d l=%0b, want v=1 d=%0d c=%0d l=%0b",
                         out_valid, out_data, out_col, out_last, exp_b.data, exp_b.col, exp_b.last);
            end
            if (i == N - 1) start_collection(BUS_B);
            else tick();
        end
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: got busy=%0b valid=%0b ovr=%0b, want 1 0 1", busy, out_valid, overrun);
        end
        for (int i = 1; i < LAT; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL b2b_early_valid: cycle %0d got valid=%0b, want 0", i, out_valid);
            end
        end
        tick();
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                exp_b = sb[0];
                tests_run++;
                if ({out_data, out_col, out_last, out_sat} !== exp_b) begin
                    fails++;
                    $display("FAIL b2b_second_beat: got d=%0d c=%0d, want d=%0d c=%0d",
                             out_data, out_col, exp_b.data, exp_b.col);
                end
                void'(sb.pop_front());
            end
            tick();
            cyc++;
        end
        tests_run++;
        if (sb.size() != 0 || overrun !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got left=%0d ovr=%0b busy=%0b, want 0 1 0", sb.size(), overrun, busy);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        out_ready = 1'b1;
        start_collection(BUS_S);
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                exp_b = sb[0];
                tests_run++;
                if ({out_data, out_col, out_last, out_sat} !== exp_b) begin
                    fails++;
                    $display("FAIL sat_beat: got d=%0d c=%0d s=%0b, want d=%0d c=%0d s=%0b",
                             out_data, out_col, out_sat, exp_b.data, exp_b.col, exp_b.sat);
                end
                void'(sb.pop_front());
            end
            tick();
            cyc++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sat_end: got %0d beats missing, want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        out_ready = 1'b1;
        start_collection(BUS_A);
        for (int i = 0; i < LAT; i++) tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        tests_run++;
        if ({out_valid, out_data, out_col, out_last, out_sat, busy, overrun} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got v=%0b d=%0d c=%0d l=%0b b=%0b o=%0b, want all 0",
                     out_valid, out_data, out_col, out_last, busy, overrun);
        end
        start_collection(BUS_B);
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                exp_b = sb[0];
                tests_run++;
                if ({out_data, out_col, out_last, out_sat} !== exp_b) begin
                    fails++;
                    $display("FAIL rst_mid_redrain: got d=%0d c=%0d, want d=%0d c=%0d",
                             out_data, out_col, exp_b.data, exp_b.col);
                end
                void'(sb.pop_front());
            end
            tick();
            cyc++;
        end
        tests_run++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_end: got left=%0d busy=%0b, want 0 0", sb.size(), busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        acc_in    = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_snapshot_isolation();
        test_overrun_back_to_back();
        test_saturation();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
